// File: rtl/xava_obi_pkg.sv
// Shared types and helpers for the OBI data-port arbiter.
package xava_obi_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Index width that stays at least one bit even for a single-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xava_obi_rsp_fifo.sv
// Index FIFO remembering which master owns each accepted-but-unanswered transaction.
module xava_obi_rsp_fifo
    import xava_obi_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PW = idx_w(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/xava_obi_data_arbiter.sv
// N-master to 1-slave OBI data-port arbiter with address-phase locking,
// pipelined outstanding transactions and in-order response routing.
module xava_obi_data_arbiter
    import xava_obi_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ARB_MODE        = 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_MASTERS-1:0]                m_req_i,
    output logic [NUM_MASTERS-1:0]                m_gnt_o,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_addr_i,
    input  logic [NUM_MASTERS-1:0]                m_we_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_be_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wdata_i,
    output logic [NUM_MASTERS-1:0]                m_rvalid_o,
    output logic [DATA_WIDTH-1:0]                 m_rdata_o,
    output logic                                  s_req_o,
    input  logic                                  s_gnt_i,
    output logic [ADDR_WIDTH-1:0]                 s_addr_o,
    output logic                                  s_we_o,
    output logic [DATA_WIDTH/8-1:0]               s_be_o,
    output logic [DATA_WIDTH-1:0]                 s_wdata_o,
    input  logic                                  s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                 s_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
    output logic                                  err_o
);
    localparam int IW = idx_w(NUM_MASTERS);
    localparam int BW = DATA_WIDTH / 8;
    localparam bit RR = (ARB_MODE == int'(ARB_RR));

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_lock_sel;
    logic          r_locked;
    logic          r_err;
    logic [IW-1:0] w_cand;
    logic [IW-1:0] w_sel_free;
    logic          w_found;
    logic [IW-1:0] w_sel;
    logic [IW-1:0] w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_hs;
    logic          w_rsp;

    // Scan from the RR pointer (or from index 0 in fixed mode) for the first requester.
    always_comb begin
        w_cand     = '0;
        w_sel_free = '0;
        w_found    = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_cand = RR ? IW'((int'(r_ptr) + i) % NUM_MASTERS) : IW'(i);
            if (!w_found && m_req_i[w_cand]) begin
                w_sel_free = w_cand;
                w_found    = 1'b1;
            end
        end
    end

    assign w_sel   = r_locked ? r_lock_sel : w_sel_free;
    // full is registered, so a same-cycle response never re-opens the request path.
    assign s_req_o = (|m_req_i) & ~w_full & ~rst_i;
    assign w_hs    = s_req_o & s_gnt_i;
    assign w_rsp   = s_rvalid_i & ~w_empty;

    assign s_addr_o  = s_req_o ? m_addr_i[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign s_we_o    = s_req_o & m_we_i[w_sel];
    assign s_be_o    = s_req_o ? m_be_i[int'(w_sel)*BW +: BW] : '0;
    assign s_wdata_o = s_req_o ? m_wdata_i[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign m_rdata_o = s_rdata_i;
    assign err_o     = r_err;

    always_comb begin
        m_gnt_o        = '0;
        m_gnt_o[w_sel] = w_hs;
    end

    always_comb begin
        m_rvalid_o         = '0;
        m_rvalid_o[w_head] = w_rsp;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr      <= '0;
            r_lock_sel <= '0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_hs) begin
                r_locked <= 1'b0;
                if (RR) begin
                    r_ptr <= (w_sel == IW'(NUM_MASTERS - 1)) ? '0 : w_sel + 1'b1;
                end
            end else if (s_req_o && !r_locked) begin
                r_locked   <= 1'b1;
                r_lock_sel <= w_sel;
            end
            if (s_rvalid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    xava_obi_rsp_fifo #(
        .WIDTH (IW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_hs),
        .i_data  (w_sel),
        .i_pop   (s_rvalid_i),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (outstanding_o)
    );

    a_one_gnt: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(m_gnt_o));
    a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (s_req_o && !s_gnt_i) |=> (s_addr_o == $past(s_addr_o)));

endmodule

// File: tb/tb_xava_obi_data_arbiter.sv
// Directed bench: round-robin 2-master instance checked through a grant/response
// scoreboard, plus a 3-master fixed-priority instance for starvation behaviour.
module tb_xava_obi_data_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;
    localparam logic [31:0] W0 = 32'h1111_0000;
    localparam logic [31:0] W1 = 32'h2222_0000;
    localparam logic [31:0] B0 = 32'h0000_A000;
    localparam logic [31:0] B1 = 32'h0000_B000;
    localparam logic [31:0] B2 = 32'h0000_C000;

    int checks   = 0;
    int failures = 0;

    // ---------------- round-robin DUT (N=2) ----------------
    logic [1:0]  rr_req    = '0;
    logic [1:0]  rr_gnt;
    logic [63:0] rr_addr   = {A1, A0};
    logic [1:0]  rr_we     = '0;
    logic [7:0]  rr_be     = {4'h3, 4'hF};
    logic [63:0] rr_wdata  = {W1, W0};
    logic [1:0]  rr_rvalid;
    logic [31:0] rr_rdata;
    logic        rr_sreq;
    logic        rr_sgnt   = 1'b0;
    logic [31:0] rr_saddr;
    logic        rr_swe;
    logic [3:0]  rr_sbe;
    logic [31:0] rr_swdata;
    logic        rr_srvalid = 1'b0;
    logic [31:0] rr_srdata  = '0;
    logic [1:0]  rr_out;
    logic        rr_err;

    xava_obi_data_arbiter #(
        .NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2), .ARB_MODE(1)
    ) dut_rr (
        .clk_i(clk), .rst_i(rst),
        .m_req_i(rr_req), .m_gnt_o(rr_gnt), .m_addr_i(rr_addr), .m_we_i(rr_we),
        .m_be_i(rr_be), .m_wdata_i(rr_wdata), .m_rvalid_o(rr_rvalid), .m_rdata_o(rr_rdata),
        .s_req_o(rr_sreq), .s_gnt_i(rr_sgnt), .s_addr_o(rr_saddr), .s_we_o(rr_swe),
        .s_be_o(rr_sbe), .s_wdata_o(rr_swdata), .s_rvalid_i(rr_srvalid), .s_rdata_i(rr_srdata),
        .outstanding_o(rr_out), .err_o(rr_err)
    );

    // ---------------- fixed-priority DUT (N=3) ----------------
    logic [2:0]  fx_req    = '0;
    logic [2:0]  fx_gnt;
    logic [95:0] fx_addr   = {B2, B1, B0};
    logic [2:0]  fx_we     = '0;
    logic [11:0] fx_be     = '1;
    logic [95:0] fx_wdata  = '0;
    logic [2:0]  fx_rvalid;
    logic [31:0] fx_rdata;
    logic        fx_sreq;
    logic        fx_sgnt   = 1'b0;
    logic [31:0] fx_saddr;
    logic        fx_swe;
    logic [3:0]  fx_sbe;
    logic [31:0] fx_swdata;
    logic        fx_srvalid = 1'b0;
    logic [31:0] fx_srdata  = '0;
    logic [1:0]  fx_out;
    logic        fx_err;

    xava_obi_data_arbiter #(
        .NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2), .ARB_MODE(0)
    ) dut_fx (
        .clk_i(clk), .rst_i(rst),
        .m_req_i(fx_req), .m_gnt_o(fx_gnt), .m_addr_i(fx_addr), .m_we_i(fx_we),
        .m_be_i(fx_be), .m_wdata_i(fx_wdata), .m_rvalid_o(fx_rvalid), .m_rdata_o(fx_rdata),
        .s_req_o(fx_sreq), .s_gnt_i(fx_sgnt), .s_addr_o(fx_saddr), .s_we_o(fx_swe),
        .s_be_o(fx_sbe), .s_wdata_o(fx_swdata), .s_rvalid_i(fx_srvalid), .s_rdata_i(fx_srdata),
        .outstanding_o(fx_out), .err_o(fx_err)
    );

    // ---------------- scoreboard ----------------
    logic [33:0] exp_gnt_q[$];
    logic [33:0] exp_rsp_q[$];
    logic [33:0] mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rr_gnt != 2'b00) begin
                if (exp_gnt_q.size() == 0) begin
                    chk("gnt_unexpected", {30'd0, rr_gnt, rr_saddr}, 64'd0);
                end else begin
                    mon_e = exp_gnt_q.pop_front();
                    chk("gnt_addr", {30'd0, rr_gnt, rr_saddr}, {30'd0, mon_e});
                end
            end
            if (rr_rvalid != 2'b00) begin
                if (exp_rsp_q.size() == 0) begin
                    chk("rsp_unexpected", {30'd0, rr_rvalid, rr_rdata}, 64'd0);
                end else begin
                    mon_e = exp_rsp_q.pop_front();
                    chk("rsp_route", {30'd0, rr_rvalid, rr_rdata}, {30'd0, mon_e});
                end
            end
        end
    end

    // Masters keep requesting until granted.
    a_req_hold0: assert property (@(posedge clk) disable iff (rst)
        (rr_req[0] && !rr_gnt[0]) |=> rr_req[0])
        else begin checks++; failures++; $display("FAIL req_hold0: master 0 dropped req before gnt"); end
    a_req_hold1: assert property (@(posedge clk) disable iff (rst)
        (rr_req[1] && !rr_gnt[1]) |=> rr_req[1])
        else begin checks++; failures++; $display("FAIL req_hold1: master 1 dropped req before gnt"); end

    // ---------------- driver tasks ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rd);
        rr_req     = req;
        rr_sgnt    = gnt;
        rr_srvalid = rv;
        rr_srdata  = rd;
    endtask

    task automatic report();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        #100000;
        checks++;
        failures++;
        $display("FAIL watchdog: run did not complete in time");
        report();
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        repeat (2) @(posedge clk);
        neg();
        chk("rst_sreq", {63'd0, rr_sreq}, 64'd0);
        chk("rst_out", {62'd0, rr_out}, 64'd0);
        chk("rst_err", {63'd0, rr_err}, 64'd0);
        chk("rst_gnt", {62'd0, rr_gnt}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: both masters request, slave always grants, responses one cycle later
        for (int i = 0; i < 6; i++) begin
            d = 32'hA000_0000 + 32'(i) - 32'd1;
            drive((i < 4) ? 2'b11 : ((i == 4) ? 2'b01 : 2'b00), 1'b1, (i > 0), d);
            if (i < 5) exp_gnt_q.push_back((i % 2 == 0) ? {2'b01, A0} : {2'b10, A1});
            if (i > 0) exp_rsp_q.push_back(((i - 1) % 2 == 0) ? {2'b01, d} : {2'b10, d});
            nxt();
        end
        drive(2'b00, 1'b0, 1'b0, '0);
        chk("t1_out", {62'd0, rr_out}, 64'd0);

        // 3: slave stalls; m0 locked even though the RR pointer favours m1
        drive(2'b01, 1'b0, 1'b0, '0);
        neg();
        chk("t3_sreq", {63'd0, rr_sreq}, 64'd1);
        chk("t3_addr0", {32'd0, rr_saddr}, {32'd0, A0});
        nxt();
        for (int i = 0; i < 2; i++) begin
            drive(2'b11, 1'b0, 1'b0, '0);
            neg();
            chk("t3_addr_lock", {32'd0, rr_saddr}, {32'd0, A0});
            nxt();
        end
        drive(2'b11, 1'b1, 1'b0, '0);
        exp_gnt_q.push_back({2'b01, A0});
        nxt();
        drive(2'b10, 1'b1, 1'b0, '0);
        exp_gnt_q.push_back({2'b10, A1});
        nxt();
        drive(2'b00, 1'b0, 1'b1, 32'h3333_0000);
        exp_rsp_q.push_back({2'b01, 32'h3333_0000});
        nxt();
        drive(2'b00, 1'b0, 1'b1, 32'h3333_0001);
        exp_rsp_q.push_back({2'b10, 32'h3333_0001});
        nxt();

        // 4: outstanding limit reached, one-cycle bubble after the first response
        drive(2'b01, 1'b1, 1'b0, '0);
        exp_gnt_q.push_back({2'b01, A0});
        nxt();
        drive(2'b10, 1'b1, 1'b0, '0);
        exp_gnt_q.push_back({2'b10, A1});
        nxt();
        drive(2'b01, 1'b1, 1'b0, '0);
        neg();
        chk("t4_full_sreq", {63'd0, rr_sreq}, 64'd0);
        chk("t4_full_out", {62'd0, rr_out}, 64'd2);
        nxt();
        drive(2'b01, 1'b1, 1'b1, 32'h4444_0000);
        exp_rsp_q.push_back({2'b01, 32'h4444_0000});
        neg();
        chk("t4_bubble_sreq", {63'd0, rr_sreq}, 64'd0);
        nxt();
        drive(2'b01, 1'b1, 1'b0, '0);
        exp_gnt_q.push_back({2'b01, A0});
        neg();
        chk("t4_reopen_sreq", {63'd0, rr_sreq}, 64'd1);
        nxt();
        drive(2'b00, 1'b0, 1'b1, 32'h4444_0001);
        exp_rsp_q.push_back({2'b10, 32'h4444_0001});
        nxt();
        drive(2'b00, 1'b0, 1'b1, 32'h4444_0002);
        exp_rsp_q.push_back({2'b01, 32'h4444_0002});
        nxt();
        drive(2'b00, 1'b0, 1'b0, '0);
        chk("t4_out", {62'd0, rr_out}, 64'd0);

        // 5: m0 read then m1 write, back-to-back responses
        rr_we = 2'b10;
        drive(2'b01, 1'b1, 1'b0, '0);
        exp_gnt_q.push_back({2'b01, A0});
        neg();
        chk("t5_we0", {63'd0, rr_swe}, 64'd0);
        nxt();
        drive(2'b10, 1'b1, 1'b0, '0);
        exp_gnt_q.push_back({2'b10, A1});
        neg();
        chk("t5_we1", {63'd0, rr_swe}, 64'd1);
        chk("t5_wdata1", {32'd0, rr_swdata}, {32'd0, W1});
        chk("t5_be1", {60'd0, rr_sbe}, 64'h3);
        nxt();
        drive(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF);
        exp_rsp_q.push_back({2'b01, 32'hDEAD_BEEF});
        nxt();
        drive(2'b00, 1'b0, 1'b1, 32'h0000_0000);
        exp_rsp_q.push_back({2'b10, 32'h0000_0000});
        nxt();
        rr_we = 2'b00;
        drive(2'b00, 1'b0, 1'b0, '0);

        // 6: stray response sets the sticky error; reset mid-burst clears everything
        drive(2'b00, 1'b0, 1'b1, 32'h5555_5555);
        neg();
        chk("t6_stray_rvalid", {62'd0, rr_rvalid}, 64'd0);
        nxt();
        drive(2'b00, 1'b0, 1'b0, '0);
        neg();
        chk("t6_err_set", {63'd0, rr_err}, 64'd1);
        nxt();
        neg();
        chk("t6_err_sticky", {63'd0, rr_err}, 64'd1);
        nxt();
        drive(2'b01, 1'b1, 1'b0, '0);
        exp_gnt_q.push_back({2'b01, A0});
        nxt();
        drive(2'b10, 1'b1, 1'b0, '0);
        exp_gnt_q.push_back({2'b10, A1});
        nxt();
        rst = 1'b1;
        drive(2'b00, 1'b0, 1'b0, '0);
        nxt();
        rst = 1'b0;
        neg();
        chk("t6_rst_err", {63'd0, rr_err}, 64'd0);
        chk("t6_rst_out", {62'd0, rr_out}, 64'd0);
        chk("t6_rst_sreq", {63'd0, rr_sreq}, 64'd0);
        chk("t6_rst_outs", {30'd0, rr_gnt, rr_rvalid, 1'b0, rr_swe, rr_sbe, 24'd0}, 64'd0);
        nxt();
        drive(2'b10, 1'b1, 1'b0, '0);
        exp_gnt_q.push_back({2'b10, A1});
        nxt();
        drive(2'b00, 1'b0, 1'b1, 32'h6666_0000);
        exp_rsp_q.push_back({2'b10, 32'h6666_0000});
        nxt();
        drive(2'b00, 1'b0, 1'b0, '0);
        chk("t6_final_out", {62'd0, rr_out}, 64'd0);
        chk("t6_final_err", {63'd0, rr_err}, 64'd0);

        // 2: fixed priority, master 0 starves 1 and 2 until it drops its request
        fx_sgnt = 1'b1;
        fx_req  = 3'b111;
        neg();
        chk("t2_gnt_c0", {61'd0, fx_gnt}, 64'b001);
        chk("t2_addr_c0", {32'd0, fx_saddr}, {32'd0, B0});
        nxt();
        fx_srvalid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            neg();
            chk("t2_gnt_m0", {61'd0, fx_gnt}, 64'b001);
            chk("t2_rvalid_m0", {61'd0, fx_rvalid}, 64'b001);
            nxt();
        end
        fx_req = 3'b110;
        neg();
        chk("t2_gnt_m1a", {61'd0, fx_gnt}, 64'b010);
        chk("t2_addr_m1", {32'd0, fx_saddr}, {32'd0, B1});
        chk("t2_rvalid_c3", {61'd0, fx_rvalid}, 64'b001);
        nxt();
        neg();
        chk("t2_gnt_m1b", {61'd0, fx_gnt}, 64'b010);
        chk("t2_rvalid_c4", {61'd0, fx_rvalid}, 64'b010);
        nxt();
        fx_req = 3'b100;
        neg();
        chk("t2_gnt_m2", {61'd0, fx_gnt}, 64'b100);
        chk("t2_rvalid_c5", {61'd0, fx_rvalid}, 64'b010);
        nxt();
        fx_req  = 3'b000;
        fx_sgnt = 1'b0;
        neg();
        chk("t2_rvalid_c6", {61'd0, fx_rvalid}, 64'b100);
        nxt();
        fx_srvalid = 1'b0;
        chk("t2_out", {62'd0, fx_out}, 64'd0);
        chk("t2_err", {63'd0, fx_err}, 64'd0);

        // ---------------- final report ----------------
        nxt();
        chk("gnt_q_drained", 64'(exp_gnt_q.size()), 64'd0);
        chk("rsp_q_drained", 64'(exp_rsp_q.size()), 64'd0);
        report();
        $finish;
    end

endmodule
